spi_slave_regfile: RTL
======================

# spi_slave_regfile

Chip-side SPI responder that terminates the 4-wire SPI link driven by the FPGA test harness (`spi_sck`, `spi_mosi`, `spi_miso`, `spi_cs`). It decodes fixed 16-bit frames into register writes and reads against an internal bank of 8-bit configuration registers, and exposes those registers to chip logic. It oversamples all SPI pins in the `CLK` domain, so it contains no SCK-clocked logic. It serves both as the chip's configuration front end and as the loopback model on the test FPGA.

## Interface
- `NREG`, 16: number of 8-bit registers; addresses `0..NREG-1` are valid; legal range is 1..128.
- `RST_VAL`, 8'h00: reset value of every register.

- `CLK`  in  1  process clock; must be at least 8x SCK frequency.
- `rst_n`  in  1  asynchronous, active-low reset.
- `spi_sck`  in  1  SPI clock, mode 0 (CPOL=0, CPHA=0); asynchronous to `CLK`.
- `spi_cs`  in  1  chip select, active-low.
- `spi_mosi`  in  1  master-to-slave data, MSB first.
- `spi_miso`  out  1  slave-to-master data, MSB first.
- `spi_miso_oe`  out  1  MISO drive enable; 1 only while a read data phase is active.
- `reg_flat`  out  8*NREG  register bank; register k occupies bits `[8k+7:8k]`.
- `wr_valid`  out  1  one-cycle pulse when a register write commits.
- `wr_addr`  out  7  address of the committed write; holds its value between pulses.
- `wr_data`  out  8  data of the committed write; holds its value between pulses.
- `frame_err`  out  1  one-cycle pulse when `spi_cs` rises after a frame that is not exactly 16 bits long.

## Operation
- **Synchronisers:** `spi_sck`, `spi_cs` and `spi_mosi` each pass through a 2-FF synchroniser. Rise and fall detection uses the second stage and a third delay flop.
- **Frame format:** bit 15 is R/W (1 = write, 0 = read), bits 14:8 are the address, bits 7:0 are data. Bits are sent MSB first. MOSI is sampled on each detected SCK rise while CS is low.
- **State `IDLE`:** CS is high; the bit counter is cleared. A detected CS fall moves to `CMD`.
- **State `CMD`:** shift 8 MOSI bits. On the 8th rise, latch R/W and address, then go to `DATA`.
  - For a read, load the read shift register with `reg[addr]`, or 8'h00 if `addr >= NREG`.
- **State `DATA`:** shift 8 more bits.
  - For a read, MISO updates on detected SCK falls. The 8th fall presents bit 7; the 9th through 15th falls present bits 6..0.
  - For a write, the 16th rise commits the write: if `addr < NREG`, the register updates. `wr_valid` pulses even when `addr >= NREG`, reporting that address; in that case the register bank is unchanged.
  - After the 16th rise, go to `DONE`.
- **State `DONE`:** further SCK edges are ignored and MISO is held at 0.
- **Abort:** a detected CS rise in any state returns to `IDLE`.
  - `frame_err` pulses if the bit count is neither 0 nor 16 (counter saturates at 17).
  - A write is never committed by a short frame.
- **MISO control:**
  - `spi_miso_oe` = 1 from the 8th fall of a read frame until CS rises. It is 0 at all other times.
  - `spi_miso` = 0 whenever `spi_miso_oe` = 0.
- **Reset:** asynchronous reset at any time, including mid-frame, forces the following values:
  - state `IDLE`
  - counters 0
  - all registers = `RST_VAL`
  - `wr_valid` = 0, `frame_err` = 0, `spi_miso` = 0, `spi_miso_oe` = 0
  - `wr_addr` = 0, `wr_data` = 0

  The first frame after reset deassertion is valid only if CS falls after reset is released.

## Timing
- **Pin-to-detect latency:** 3 `CLK` cycles from a pin edge to the internal edge pulse.
- **SCK limits:** SCK high and low times must each be at least 4 `CLK` cycles. CS setup to the first SCK rise must be at least 4 `CLK` cycles.
- **MISO valid:** at most 4 `CLK` cycles after the SCK fall at the pin, so it is valid before the next rise.
- **Write commit:** the register and `wr_valid` update on the `CLK` edge after the detected 16th rise. That is 4 `CLK` cycles after the pin edge. `reg_flat` shows the new value in the same cycle that `wr_valid` is high.
- **Read snapshot:** the read value is captured at the 8th rise. A write to the same address committed later does not alter data already being shifted.
- **Simultaneous events:** if a CS rise and an SCK rise are detected in the same cycle, CS takes priority; the SCK edge is ignored.
- **Back-to-back frames:** CS high time of at least 4 `CLK` cycles is sufficient.

## Test plan
- **Reset:** after reset, read addresses 0..15. Expect MISO = 0x00 for each, no `frame_err`, and `reg_flat` all zero.
- **Write:** write 0xA5 to address 3. Expect `wr_valid` for exactly 1 cycle with `wr_addr` = 3 and `wr_data` = 0xA5, and `reg_flat[31:24]` = 0xA5. A subsequent read of address 3 returns 0xA5 on MISO, with `spi_miso_oe` high during bits 7..0 only.
- **Out-of-range address:** write 0x5A to address 20 with `NREG` = 16. Expect `wr_valid` with `wr_addr` = 20 and `reg_flat` unchanged. A read of address 20 returns 0x00.
- **Short frame:** write 0xFF to address 1, raising CS after 12 bits. Expect a `frame_err` pulse, no `wr_valid`, and register 1 unchanged. Next, send an 18-bit write frame of 0x11 to address 2: register 2 = 0x11, `wr_valid` pulses once, then `frame_err` pulses at the CS rise.
- **Minimum SCK timing:** with SCK half period = 4 `CLK` cycles and random SCK/`CLK` phase, run 200 random read and write frames checked against a reference model. Expect zero mismatches.
- **Reset mid-frame:** assert `rst_n` during bit 10 of a write to address 5. Expect register 5 = `RST_VAL`, no `wr_valid`, and MISO and `spi_miso_oe` = 0. The next full frame behaves normally.

Source files
------------

// File: rtl/spi_slave_regfile.sv
// SPI mode-0 responder oversampled in CLK: 16-bit frames {rw, addr[6:0], data[7:0]} access a bank of 8-bit registers.
// Pin-to-detect latency is 3 CLK cycles; there is no backpressure, and the SPI master paces every transfer.
module spi_slave_regfile #(
  parameter int         NREG    = 16,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic              CLK,
  input  logic              rst_n,
  input  logic              spi_sck,
  input  logic              spi_cs,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              spi_miso_oe,
  output logic [8*NREG-1:0] reg_flat,
  output logic              wr_valid,
  output logic [6:0]        wr_addr,
  output logic [7:0]        wr_data,
  output logic              frame_err
);

  typedef enum logic [1:0] {IDLE, CMD, DATA, DONE} state_t;

  state_t      state_q, state_d;
  logic [2:0]  sck_q, sck_d, cs_q, cs_d;
  logic [1:0]  mosi_q, mosi_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [7:0]  sh_q, sh_d, rd_sh_q, rd_sh_d;
  logic        rw_q, rw_d;
  logic [6:0]  addr_q, addr_d;
  logic        miso_q, miso_d, oe_q, oe_d;
  logic        wr_valid_q, wr_valid_d, frame_err_q, frame_err_d;
  logic [6:0]  wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic [7:0]  regs_q [NREG];
  logic [7:0]  regs_d [NREG];
  logic        sck_rise, sck_fall, cs_rise, cs_fall;
  logic [7:0]  shifted, rd_val;

  // Edge detect on the second synchroniser stage against the third delay flop.
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign shifted  = {sh_q[6:0], mosi_q[1]};

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (cs_rise) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (cs_fall) state_d = CMD;
        CMD:     if (sck_rise && cnt_q == 5'd7) state_d = DATA;
        DATA:    if (sck_rise && cnt_q == 5'd15) state_d = DONE;
        default: state_d = state_q;
      endcase
    end
  end

  always_comb begin
    rd_val = 8'h00;
    for (int k = 0; k < NREG; k++) begin
      if (shifted[6:0] == 7'(k)) rd_val = regs_q[k];
    end
  end

  always_comb begin
    sck_d       = {sck_q[1:0], spi_sck};
    cs_d        = {cs_q[1:0], spi_cs};
    mosi_d      = {mosi_q[0], spi_mosi};
    cnt_d       = cnt_q;
    sh_d        = sh_q;
    rd_sh_d     = rd_sh_q;
    rw_d        = rw_q;
    addr_d      = addr_q;
    miso_d      = miso_q;
    oe_d        = oe_q;
    regs_d      = regs_q;
    wr_valid_d  = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    frame_err_d = 1'b0;
    // CS rise wins over any SCK edge seen in the same cycle.
    if (cs_rise) begin
      frame_err_d = (cnt_q != 5'd0) && (cnt_q != 5'd16);
      cnt_d       = 5'd0;
      miso_d      = 1'b0;
      oe_d        = 1'b0;
    end else if (state_q == IDLE) begin
      cnt_d = 5'd0;
    end else begin
      if (sck_rise) begin
        if (cnt_q != 5'd17) cnt_d = cnt_q + 5'd1;
        if (state_q == CMD || state_q == DATA) sh_d = shifted;
        if (state_q == CMD && cnt_q == 5'd7) begin
          rw_d    = shifted[7];
          addr_d  = shifted[6:0];
          rd_sh_d = rd_val;
        end
        if (state_q == DATA && cnt_q == 5'd15) begin
          miso_d = 1'b0;
          if (rw_q) begin
            wr_valid_d = 1'b1;
            wr_addr_d  = addr_q;
            wr_data_d  = shifted;
            for (int k = 0; k < NREG; k++) begin
              if (addr_q == 7'(k)) regs_d[k] = shifted;
            end
          end
        end
      end
      if (sck_fall && state_q == DATA && !rw_q) begin
        miso_d  = rd_sh_q[7];
        rd_sh_d = {rd_sh_q[6:0], 1'b0};
        oe_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      sck_q       <= 3'b000;
      cs_q        <= 3'b111;
      mosi_q      <= 2'b00;
      cnt_q       <= 5'd0;
      sh_q        <= 8'h00;
      rd_sh_q     <= 8'h00;
      rw_q        <= 1'b0;
      addr_q      <= 7'd0;
      miso_q      <= 1'b0;
      oe_q        <= 1'b0;
      wr_valid_q  <= 1'b0;
      wr_addr_q   <= 7'd0;
      wr_data_q   <= 8'h00;
      frame_err_q <= 1'b0;
      for (int k = 0; k < NREG; k++) regs_q[k] <= RST_VAL;
    end else begin
      sck_q       <= sck_d;
      cs_q        <= cs_d;
      mosi_q      <= mosi_d;
      cnt_q       <= cnt_d;
      sh_q        <= sh_d;
      rd_sh_q     <= rd_sh_d;
      rw_q        <= rw_d;
      addr_q      <= addr_d;
      miso_q      <= miso_d;
      oe_q        <= oe_d;
      wr_valid_q  <= wr_valid_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      frame_err_q <= frame_err_d;
      regs_q      <= regs_d;
    end
  end

  for (genvar g = 0; g < NREG; g++) begin : g_flat
    assign reg_flat[8*g +: 8] = regs_q[g];
  end

  assign spi_miso    = miso_q & oe_q;
  assign spi_miso_oe = oe_q;
  assign wr_valid    = wr_valid_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign frame_err   = frame_err_q;

endmodule
